uart_tx_fifo: RTL

//  Parametrised UART transmitter with transmit FIFO; next generation of uart_tx in the LPC serial device.

---
 rtl/lpc_uart_pkg.sv | 32 +++
 rtl/uart_tx_fifo_if.sv | 27 ++
 rtl/sync_fifo.sv | 75 +++++++
 rtl/uart_tx_fifo.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/lpc_uart_pkg.sv
// Shared types and constants for the LPC serial device UART blocks.
package lpc_uart_pkg;

  localparam int unsigned DEFAULT_CLK_DIV = 286;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2,
    PAR_MARK = 2'd3
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  // Parity bit for a frame, given the XOR-reduction of its payload.
  function automatic logic parity_bit(parity_e mode, logic data_xor);
    logic bit_v;
    case (mode)
      PAR_ODD:  bit_v = ~data_xor;
      PAR_EVEN: bit_v = data_xor;
      default:  bit_v = 1'b1;  // mark; with PAR_NONE the bit is never sent
    endcase
    return bit_v;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte-write and status bundle between the LPC decoder and the UART transmitter.
interface uart_tx_fifo_if #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16
);
  localparam int unsigned LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_data_valid;
  logic [1:0]           parity_mode;
  logic                 stop2;
  logic                 UART_TX;
  logic                 tx_busy;
  logic                 tx_full;
  logic [LEVEL_W-1:0]   tx_level;
  logic                 tx_overflow;

  modport master (
    output tx_data, tx_data_valid, parity_mode, stop2,
    input  UART_TX, tx_busy, tx_full, tx_level, tx_overflow
  );

  modport slave (
    input  tx_data, tx_data_valid, parity_mode, stop2,
    output UART_TX, tx_busy, tx_full, tx_level, tx_overflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with separate occupancy counter; full/empty are registered.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned LEVEL_W = PTR_W + 1;

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0] count_q, count_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               push_ok;
  logic               pop_ok;

  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && !empty_q;

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + LEVEL_W'(1);
      2'b01:   count_d = count_q - LEVEL_W'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == LEVEL_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  // Control registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO: frames bytes with start, optional parity and 1/2 stop bits.
module uart_tx_fifo
  import lpc_uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CLK_DIV    = DEFAULT_CLK_DIV
) (
  input  logic           LPC_CLK,
  input  logic           LPC_RST,
  uart_tx_fifo_if.slave  bus
);
  localparam int unsigned DIV_W   = $clog2(CLK_DIV);
  localparam int unsigned BIT_W   = $clog2(DATA_BITS);
  localparam int unsigned LEVEL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop2_q, stop2_d;
  logic                 line_q, line_d;
  logic                 busy_q, busy_d;
  logic                 ovf_q, ovf_d;

  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_head;
  logic [LEVEL_W-1:0]   fifo_level;
  logic                 bit_end;
  parity_e              mode_in;

  assign mode_in = parity_e'(bus.parity_mode);
  assign bit_end = (div_q == DIV_LAST);

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (LPC_CLK),
    .rst_i   (LPC_RST),
    .push_i  (bus.tx_data_valid),
    .data_i  (bus.tx_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Frame sequencing; the line value is computed from the current state and registered.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    fifo_pop  = 1'b0;
    line_d    = 1'b1;
    busy_d    = (state_q != TX_IDLE) || (fifo_level != '0);
    ovf_d     = bus.tx_data_valid && fifo_full;

    if (state_q != TX_IDLE) div_d = bit_end ? '0 : div_q + DIV_W'(1);

    case (state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          // Parity is precomputed here since the shift register is consumed during DATA.
          fifo_pop  = 1'b1;
          shift_d   = fifo_head;
          par_en_d  = (mode_in != PAR_NONE);
          par_bit_d = parity_bit(mode_in, ^fifo_head);
          stop2_d   = bus.stop2;
          div_d     = '0;
          bit_d     = '0;
          state_d   = TX_START;
        end
      end
      TX_START: begin
        line_d = 1'b0;
        if (bit_end) state_d = TX_DATA;
      end
      TX_DATA: begin
        line_d = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = par_en_q ? TX_PARITY : TX_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      TX_PARITY: begin
        line_d = par_bit_q;
        if (bit_end) state_d = TX_STOP;
      end
      TX_STOP: begin
        // bit_q counts stop bits sent so far.
        line_d = 1'b1;
        if (bit_end) begin
          if (stop2_q && (bit_q == '0)) begin
            bit_d = BIT_W'(1);
          end else begin
            bit_d   = '0;
            state_d = TX_IDLE;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any frame and forces the line idle.
  always_ff @(posedge LPC_CLK) begin
    if (LPC_RST) begin
      state_q   <= TX_IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      line_q    <= 1'b1;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      line_q    <= line_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.UART_TX     = line_q;
  assign bus.tx_busy     = busy_q;
  assign bus.tx_full     = fifo_full;
  assign bus.tx_level    = fifo_level;
  assign bus.tx_overflow = ovf_q;

endmodule
